// File: rtl/ps_dropper.sv
// Packet-aligned discarder: forwards or silently consumes whole packets, deciding at SOP.
// Zero-latency combinational datapath; dropped packets are always accepted so upstream never stalls.
module ps_dropper #(
  parameter int WIDTH  = 8,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              drop,
  input  logic              clr,
  input  logic [WIDTH-1:0]  i_dat,
  input  logic              i_val,
  input  logic              i_eop,
  output logic              i_rdy,
  output logic [WIDTH-1:0]  o_dat,
  output logic              o_val,
  output logic              o_eop,
  input  logic              o_rdy,
  output logic [CWIDTH-1:0] pass_cnt,
  output logic [CWIDTH-1:0] drop_cnt,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PASS = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_busy;
  logic [CWIDTH-1:0] r_pass_cnt;
  logic [CWIDTH-1:0] r_drop_cnt;
  logic              w_val;
  logic              w_eop;
  logic              w_rdy;
  logic              w_pass_inc;
  logic              w_drop_inc;

  always_comb begin
    w_next     = r_state;
    w_val      = 1'b0;
    w_eop      = 1'b0;
    w_rdy      = 1'b0;
    w_pass_inc = 1'b0;
    w_drop_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        // The decision follows drop on whichever SOP cycle actually accepts the beat.
        if (drop) begin
          w_rdy = 1'b1;
          if (i_val) begin
            if (i_eop) w_drop_inc = 1'b1;
            else       w_next     = S_DROP;
          end
        end else begin
          w_val = i_val;
          w_eop = i_eop;
          w_rdy = o_rdy;
          if (i_val && o_rdy) begin
            if (i_eop) w_pass_inc = 1'b1;
            else       w_next     = S_PASS;
          end
        end
      end
      S_PASS: begin
        w_val = i_val;
        w_eop = i_eop;
        w_rdy = o_rdy;
        if (i_val && o_rdy && i_eop) begin
          w_pass_inc = 1'b1;
          w_next     = S_IDLE;
        end
      end
      S_DROP: begin
        w_rdy = 1'b1;
        if (i_val && i_eop) begin
          w_drop_inc = 1'b1;
          w_next     = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_pass_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      // clr wins over a same-cycle increment; counters stick at all-ones.
      if (clr) begin
        r_pass_cnt <= '0;
        r_drop_cnt <= '0;
      end else begin
        if (w_pass_inc && (r_pass_cnt != {CWIDTH{1'b1}})) r_pass_cnt <= r_pass_cnt + 1'b1;
        if (w_drop_inc && (r_drop_cnt != {CWIDTH{1'b1}})) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  assign o_dat    = i_dat;
  assign o_val    = w_val & reset_n;
  assign o_eop    = w_eop & reset_n;
  assign i_rdy    = w_rdy & reset_n;
  assign pass_cnt = r_pass_cnt;
  assign drop_cnt = r_drop_cnt;
  assign busy     = r_busy;

endmodule

// File: tb/tb_ps_dropper.sv
// Scoreboard bench for ps_dropper: forwarded beats are queued at drive time and popped from the output.
module tb_ps_dropper;

  logic       clk;
  logic       reset_n;
  logic       drop;
  logic       clr;
  logic [7:0] i_dat;
  logic       i_val;
  logic       i_eop;
  logic       i_rdy;
  logic [7:0] o_dat;
  logic       o_val;
  logic       o_eop;
  logic       o_rdy;
  logic [3:0] pass_cnt;
  logic [3:0] drop_cnt;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cycles = 0;

  logic [8:0] sb_q[$];
  logic       m_in_pkt = 1'b0;
  logic       m_drop   = 1'b0;

  ps_dropper #(.WIDTH(8), .CWIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .drop(drop), .clr(clr),
    .i_dat(i_dat), .i_val(i_val), .i_eop(i_eop), .i_rdy(i_rdy),
    .o_dat(o_dat), .o_val(o_val), .o_eop(o_eop), .o_rdy(o_rdy),
    .pass_cnt(pass_cnt), .drop_cnt(drop_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      busy_cycles += int'(busy);
      if (o_val && o_rdy) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out", {23'd0, o_eop, o_dat}, 32'h1ff);
        end else begin
          logic [8:0] e;
          e = sb_q.pop_front();
          chk("out_dat", {24'd0, o_dat}, {24'd0, e[7:0]});
          chk("out_eop", {31'd0, o_eop}, {31'd0, e[8]});
        end
      end
    end
  end

  task automatic go_idle();
    i_val = 1'b0;
    i_eop = 1'b0;
    drop  = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    i_val = 1'b1;
    drop  = 1'b1;
    @(negedge clk);
    chk("rst_i_rdy", {31'd0, i_rdy}, 0);
    chk("rst_o_val", {31'd0, o_val}, 0);
    chk("rst_busy",  {31'd0, busy}, 0);
    go_idle();
    m_in_pkt = 1'b0;
    sb_q.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Drive one beat; the model commits the drop decision on SOP beats only.
  task automatic send_beat(input logic [7:0] d, input logic eop, input logic drp);
    bit done;
    i_dat = d;
    i_eop = eop;
    drop  = drp;
    i_val = 1'b1;
    if (!m_in_pkt) m_drop = drp;
    if (!m_drop) sb_q.push_back({eop, d});
    m_in_pkt = !eop;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (k == 0 && m_drop) chk("drop_i_rdy", {31'd0, i_rdy}, 1);
      if (i_rdy) done = 1;
    end
    if (!done) chk("hs_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b1;
    o_rdy   = 1'b1;
    i_dat   = 8'h00;
    go_idle();
    @(posedge clk);
    #1 do_reset();
    chk("reset_pass", {28'd0, pass_cnt}, 0);
    chk("reset_drop", {28'd0, drop_cnt}, 0);

    // 3-beat forwarded packet
    busy_cycles = 0;
    send_beat(8'hA1, 0, 0);
    send_beat(8'hA2, 0, 0);
    send_beat(8'hA3, 1, 0);
    go_idle();
    @(posedge clk); #1;
    chk("t1_pass", {28'd0, pass_cnt}, 1);
    chk("t1_drop", {28'd0, drop_cnt}, 0);
    chk("t1_busy_cycles", busy_cycles, 2);

    // drop on SOP only, 4 beats, then a 2-beat passed packet
    do_reset();
    send_beat(8'hB1, 0, 1);
    for (int i = 2; i <= 4; i++) send_beat(8'hB0 + 8'(i), (i == 4), 0);
    go_idle();
    @(posedge clk); #1;
    chk("t2_drop", {28'd0, drop_cnt}, 1);
    chk("t2_pass0", {28'd0, pass_cnt}, 0);
    send_beat(8'hC1, 0, 0);
    send_beat(8'hC2, 1, 0);
    go_idle();
    @(posedge clk); #1;
    chk("t2_pass1", {28'd0, pass_cnt}, 1);

    // drop raised mid-packet is ignored; next packet is discarded
    do_reset();
    send_beat(8'hD1, 0, 0);
    for (int i = 2; i <= 5; i++) send_beat(8'hD0 + 8'(i), (i == 5), 1);
    send_beat(8'hE1, 0, 1);
    send_beat(8'hE2, 1, 1);
    go_idle();
    @(posedge clk); #1;
    chk("t3_pass", {28'd0, pass_cnt}, 1);
    chk("t3_drop", {28'd0, drop_cnt}, 1);

    // stalled SOP then drop=1
    do_reset();
    o_rdy = 1'b0;
    i_dat = 8'hF1; i_eop = 1'b0; drop = 1'b0; i_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_stall_rdy", {31'd0, i_rdy}, 0);
      chk("t4_stall_busy", {31'd0, busy}, 0);
      @(posedge clk); #1;
    end
    send_beat(8'hF1, 0, 1);
    send_beat(8'hF2, 1, 0);
    go_idle();
    o_rdy = 1'b1;
    @(posedge clk); #1;
    chk("t4_drop", {28'd0, drop_cnt}, 1);
    chk("t4_pass", {28'd0, pass_cnt}, 0);

    // saturation at 15, then clr on the EOP of a passed packet
    do_reset();
    for (int i = 0; i < 17; i++) send_beat(8'(i), 1, 1);
    go_idle();
    @(posedge clk); #1;
    chk("t5_sat", {28'd0, drop_cnt}, 15);
    send_beat(8'h51, 1, 0);
    go_idle();
    @(posedge clk); #1;
    chk("t5_pass1", {28'd0, pass_cnt}, 1);
    send_beat(8'h52, 0, 0);
    clr = 1'b1;
    send_beat(8'h53, 1, 0);
    go_idle();
    @(posedge clk); #1;
    chk("t5_clr_pass", {28'd0, pass_cnt}, 0);
    chk("t5_clr_drop", {28'd0, drop_cnt}, 0);

    // reset in the middle of a dropped packet
    do_reset();
    send_beat(8'h61, 0, 1);
    send_beat(8'h62, 0, 1);
    @(negedge clk);
    chk("t6_busy_mid", {31'd0, busy}, 1);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("t6_busy_after", {31'd0, busy}, 0);
    chk("t6_drop_after", {28'd0, drop_cnt}, 0);
    @(posedge clk); #1;
    send_beat(8'h63, 1, 0);
    go_idle();
    @(posedge clk); #1;
    chk("t6_pass", {28'd0, pass_cnt}, 1);
    chk("t6_drop", {28'd0, drop_cnt}, 0);

    chk("sb_left", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
